chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
- Parametrised multi-cycle adder: WIDTH-bit operands added CHUNK bits per clock, least-significant chunk first.
- Carry is held in a register between chunks.
- Generalises the ripple adder to arbitrary width with a small per-cycle adder, carry-in, carry-out, signed overflow and valid/ready handshakes.
- Sits between operand producers and result consumers in datapaths where area outweighs latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 ≤ CHUNK ≤ WIDTH.
- (derived, localparam) NCH = WIDTH/CHUNK, chunk count. CW = clog2(NCH) (min 1), chunk index width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - All outputs and state clear on the reset edge: state=IDLE, in_ready=1 after reset, out_valid=0, sum=0, cout=0, ovf=0.
  - Internal carry, index and operand registers clear to 0.
  - Reset has priority over every other event, including mid-RUN and mid-DONE. Any in-flight operation is discarded with no out_valid.
- Three states, encoded in package:
  - IDLE: in_ready=1. On in_valid (accept edge): latch a, b, carry<=cin, idx<=0, go to RUN.
  - RUN: in_ready=0. Each cycle add chunk idx of a, b and carry; write result into sum chunk idx; carry<=chunk carry-out; idx<=idx+1.
    - On idx=NCH-1: cout<=chunk carry-out; ovf<=carry-into-MSB XOR carry-out; go to DONE.
  - DONE: out_valid=1, in_ready=0. sum/cout/ovf stable while out_valid && !out_ready.
    - On out_ready: go to IDLE, out_valid<=0.
- Latency: out_valid rises exactly NCH+1 clocks after the accept edge.
- Throughput: one operation per NCH+2 cycles minimum; no overlap of operations.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- a/b may change after the accept edge without affecting the result (operands latched).
- sum retains the last result in IDLE until overwritten during the next RUN. Partial sum is visible but not qualified during RUN.
- CHUNK=WIDTH: NCH=1, single RUN cycle; idx logic degenerates but stays legal.
- Wrap-around: arithmetic is modulo 2^WIDTH; cout flags the unsigned carry.

Optional Feature:
- CHUNK_SERIAL_ADDER_SUB_EN defined:
  - Adds input port `sub`, 1 bit, latched at the accept edge.
  - sub=1 computes a + ~b + 1, with cin ignored. cout=1 means no borrow; ovf is signed subtraction overflow.
- Undefined: no `sub` port; add only, cin used.

Decomposition:
- Package chunk_serial_adder_pkg:
  - state enum type (IDLE, RUN, DONE).
  - helper function for NCH/CW width checks.
- Sub-module chunk_add: combinational CHUNK-bit adder.
  - Inputs x, y, ci; outputs s, co.
  - Also outputs c_msb_in, the carry into its top bit, used for ovf.
  - One instance only.
- Top holds FSM, index counter, carry register and result shift/placement.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x0003, b=0x0005, cin=0 -> sum=0x0008, cout=0, ovf=0; out_valid exactly 5 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- a=0x1234, b=0x0000, cin=1 -> sum=0x1235. Toggle in_valid and a while busy -> ignored; result unchanged.
- Backpressure: out_ready=0 for 7 cycles after out_valid -> sum/cout/ovf stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- rst asserted on 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, sum=0. A following 0x000C+0x000A yields 0x0016.
- With CHUNK_SERIAL_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Also repeat case 1 with WIDTH=8, CHUNK=8 -> 1-cycle RUN, latency 2.

Source files
------------

// File: rtl/chunk_serial_adder_pkg.sv
// rtl/chunk_serial_adder_pkg.sv - state encoding and parameter helpers for the chunk-serial adder
package chunk_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk adder still keeps a 1-bit index.
  function automatic int calc_cw(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  function automatic bit widths_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_serial_adder_chunk_add.sv
// rtl/chunk_serial_adder_chunk_add.sv - combinational CHUNK-bit adder slice with carry into its top bit
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  assign s    = full[CHUNK-1:0];
  assign co   = full[CHUNK];
  // Top sum bit is x^y^carry-in, so the carry into it falls out of the sum.
  assign c_msb_in = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle adder, CHUNK bits per clock, LS chunk first
// Optional subtract mode (sub port) enabled by defining CHUNK_SERIAL_ADDER_SUB_EN.
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = calc_cw(NCH);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  if (!widths_ok(WIDTH, CHUNK)) begin : g_param_check
    $error("chunk_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             sub_q;
  logic             last_chunk;

  logic [CHUNK-1:0] cx;
  logic [CHUNK-1:0] cy;
  logic [CHUNK-1:0] cs;
  logic             cco;
  logic             cmsb;

  assign last_chunk = (idx == LAST_IDX);

  // Subtraction reuses the adder: invert B here, force carry-in at accept.
  assign cx = a_q[idx*CHUNK +: CHUNK];
  assign cy = sub_q ? ~b_q[idx*CHUNK +: CHUNK] : b_q[idx*CHUNK +: CHUNK];

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x        (cx),
    .y        (cy),
    .ci       (carry),
    .s        (cs),
    .co       (cco),
    .c_msb_in (cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)   state_n = RUN;
      RUN:     if (last_chunk) state_n = DONE;
      DONE:    if (out_ready)  state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            idx <= '0;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
            carry <= sub ? 1'b1 : cin;
`else
            carry <= cin;
`endif
          end
        end
        RUN: begin
          sum_q[idx*CHUNK +: CHUNK] <= cs;
          carry <= cco;
          if (last_chunk) begin
            cout_q <= cco;
            ovf_q  <= cmsb ^ cco;
            idx    <= '0;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_q <= sub;
    end
  end
`else
  assign sub_q = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - randomized self-checking bench with arithmetic reference model
module tb_chunk_serial_adder;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int NCH = W / C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, cin, sub_i, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]   a8, b8, sum8;

  chunk_serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Returns {ovf, cout, sum} for a w-bit add (or subtract) using plain arithmetic.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    logic [32:0] mask, full;
    logic [31:0] bb, s;
    logic        co, ov;
    mask = (33'd1 << w) - 33'd1;
    bb   = (sb ? ~bv : bv) & mask[31:0];
    full = {1'b0, av & mask[31:0]} + {1'b0, bb} + {32'd0, (sb ? 1'b1 : ci)};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s};
  endfunction

  // Transaction-level model of the 16-bit instance: pending result, accept time, last result.
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pending = 1'b0;
  bit          chk_en = 1'b0;
  logic [W-1:0] exp_sum, last_sum = '0;
  logic         exp_cout, exp_ovf, last_cout = 1'b0, last_ovf = 1'b0;

  initial begin
    logic [33:0] r;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        pending   = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
      end else if (pending && (cyc - 1 >= acc_cyc + NCH) && out_ready) begin
        last_sum  = exp_sum;
        last_cout = exp_cout;
        last_ovf  = exp_ovf;
        pending   = 1'b0;
      end else if (!pending && in_valid) begin
        r        = model(W, 32'(a), 32'(b), cin, sub_i);
        exp_sum  = r[W-1:0];
        exp_cout = r[32];
        exp_ovf  = r[33];
        acc_cyc  = cyc;
        pending  = 1'b1;
      end
    end
  end

  initial begin
    bit mvalid;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        mvalid = pending && (cyc >= acc_cyc + NCH);
        chk("cyc_in_ready", 32'(in_ready), 32'(!pending));
        chk("cyc_out_valid", 32'(out_valid), 32'(mvalid));
        if (mvalid) begin
          chk("cyc_sum", 32'(sum), 32'(exp_sum));
          chk("cyc_cout", 32'(cout), 32'(exp_cout));
          chk("cyc_ovf", 32'(ovf), 32'(exp_ovf));
        end else if (!pending) begin
          chk("idle_sum", 32'(sum), 32'(last_sum));
          chk("idle_cout", 32'(cout), 32'(last_cout));
          chk("idle_ovf", 32'(ovf), 32'(last_ovf));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the result has been consumed.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, input logic sb,
                    input int hold, input bit disturb,
                    output int lat, output logic [W-1:0] s, output logic co, output logic ov);
    int t;
    a = av; b = bv; cin = ci; sub_i = sb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(t < 50), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      if (disturb) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    s = sum; co = cout; ov = ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(s));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                     output int lat, output logic [7:0] s, output logic co, output logic ov);
    a8 = av; b8 = bv; cin8 = ci; sub8 = sb;
    in_valid8 = 1'b1;
    chk("w8_in_ready", 32'(in_ready8), 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s = sum8; co = cout8; ov = ovf8;
    @(negedge clk);
    chk("w8_post_out_valid", 32'(out_valid8), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    logic [W-1:0] s;
    logic         co, ov;
    logic [7:0]   s8;
    logic [33:0]  r;
    logic [W-1:0] av, bv;
    logic         ci, sb;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk_en = 1'b1;

    op(16'h0003, 16'h0005, 1'b0, 1'b0, 0, 1'b0, lat, s, co, ov);
    chk("lat_3p5", 32'(lat), 32'(NCH + 1));
    chk("sum_3p5", 32'(s), 32'h0008);
    chk("cout_3p5", 32'(co), 32'd0);
    chk("ovf_3p5", 32'(ov), 32'd0);

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, lat, s, co, ov);
    chk("sum_wrap", 32'(s), 32'h0000);
    chk("cout_wrap", 32'(co), 32'd1);
    chk("ovf_wrap", 32'(ov), 32'd0);

    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, lat, s, co, ov);
    chk("sum_ovf", 32'(s), 32'h8000);
    chk("cout_ovf", 32'(co), 32'd0);
    chk("ovf_ovf", 32'(ov), 32'd1);

    op(16'h1234, 16'h0000, 1'b1, 1'b0, 0, 1'b1, lat, s, co, ov);
    chk("sum_cin_disturb", 32'(s), 32'h1235);
    chk("lat_disturb", 32'(lat), 32'(NCH + 1));

    op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 7, 1'b0, lat, s, co, ov);
    chk("sum_backpressure", 32'(s), 32'h0FFF);

    a = 16'h000C; b = 16'h000A; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    op(16'h000C, 16'h000A, 1'b0, 1'b0, 0, 1'b0, lat, s, co, ov);
    chk("sum_after_rst", 32'(s), 32'h0016);

`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, lat, s, co, ov);
    chk("sub_sum", 32'(s), 32'hFFFE);
    chk("sub_cout", 32'(co), 32'd0);
    op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, lat, s, co, ov);
    chk("sub_cin_ignored", 32'(s), 32'hFFFE);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, lat, s, co, ov);
    chk("sub_ovf_sum", 32'(s), 32'h7FFF);
    chk("sub_ovf", 32'(ov), 32'd1);
`endif

    for (int n = 0; n < 40; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      ci = 1'($urandom_range(0, 1));
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`else
      sb = 1'b0;
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op(av, bv, ci, sb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat, s, co, ov);
      r = model(W, 32'(av), 32'(bv), ci, sb);
      chk("rnd_lat", 32'(lat), 32'(NCH + 1));
      chk("rnd_result", {29'd0, ov, co, 1'b0} | 32'(s != r[W-1:0]), {29'd0, r[33], r[32], 1'b0});
    end

    op8(8'h03, 8'h05, 1'b0, 1'b0, lat, s8, co, ov);
    chk("w8_lat", 32'(lat), 32'd2);
    chk("w8_sum_3p5", 32'(s8), 32'h08);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, s8, co, ov);
    chk("w8_sum_wrap", 32'(s8), 32'h00);
    chk("w8_cout_wrap", 32'(co), 32'd1);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, lat, s8, co, ov);
    chk("w8_sum_ovf", 32'(s8), 32'h80);
    chk("w8_ovf", 32'(ov), 32'd1);
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, lat, s8, co, ov);
    chk("w8_sub_sum", 32'(s8), 32'hFE);
    chk("w8_sub_cout", 32'(co), 32'd0);
`endif
    for (int n = 0; n < 10; n++) begin
      av = W'($urandom_range(0, 255));
      bv = W'($urandom_range(0, 255));
      ci = 1'($urandom_range(0, 1));
      op8(av[7:0], bv[7:0], ci, 1'b0, lat, s8, co, ov);
      r = model(8, 32'(av), 32'(bv), ci, 1'b0);
      chk("w8_rnd_sum", 32'(s8), {24'd0, r[7:0]});
      chk("w8_rnd_flags", {30'd0, ov, co}, {30'd0, r[33], r[32]});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
